// File: rtl/pwm_deadtime_gen_pkg.sv
// Shared PWM enums and the dead-time FSM state encoding.
// Pure type/constant definitions, no logic, no latency.
// No flow control; values are consumed combinationally by the PWM legs.
`ifndef DTCOUNT_WIDTH
`define DTCOUNT_WIDTH 8
`endif

package pwm_deadtime_gen_pkg;

  // Channel enable.
  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  // Dead-time insertion enable.
  typedef enum logic {
    DT_OFF = 1'b0,
    DT_ON  = 1'b1
  } _dt_onoff;

  // Output polarity; LOGIC_NEG drives active-low gates.
  typedef enum logic {
    LOGIC_POS = 1'b0,
    LOGIC_NEG = 1'b1
  } _logic_pwm;

  // Dead-time generator states.
  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_LOW     = 3'd1,
    S_DT_RISE = 3'd2,
    S_HIGH    = 3'd3,
    S_DT_FALL = 3'd4
  } _dt_state;

endpackage

// File: rtl/pwm_deadtime_gen.sv
// Dead-time insertion: raw PWM leg in, complementary high/low gate pair out.
// Latency: one clk edge to outputs; the rising/falling dead times add dt_rise/dt_fall ce ticks.
// No backpressure; a pwm_in pulse shorter than the dead time is swallowed.
`ifndef DTCOUNT_WIDTH
`define DTCOUNT_WIDTH 8
`endif

module pwm_deadtime_gen
  import pwm_deadtime_gen_pkg::*;
#(
  parameter int DT_WIDTH = `DTCOUNT_WIDTH
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ce,
  input  _pwm_onoff           pwm_on,
  input  _dt_onoff            dt_on,
  input  _logic_pwm           logic_pol,
  input  logic [DT_WIDTH-1:0] dt_rise,
  input  logic [DT_WIDTH-1:0] dt_fall,
  input  logic                pwm_in,
  output logic                pwm_h,
  output logic                pwm_l,
  output logic                dt_busy
);

  _dt_state            state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                pwm_h_q, pwm_h_d;
  logic                pwm_l_q, pwm_l_d;
  logic                dt_busy_q, dt_busy_d;
  logic                dt_eff_r, dt_eff_f;
  logic                pol;

  // A zero dead time behaves exactly like dead time disabled.
  assign dt_eff_r = (dt_on == DT_ON) && (dt_rise != '0);
  assign dt_eff_f = (dt_on == DT_ON) && (dt_fall != '0);
  assign pol      = logic'(logic_pol);

  // Next-state, counter and registered-output decode of the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (pwm_on == PWM_OFF) begin
      state_d = S_OFF;
    end else if (ce) begin
      case (state_q)
        // Leaving S_OFF always passes through dead time when it is enabled.
        S_OFF: begin
          if (pwm_in) begin
            if (dt_eff_r) begin
              state_d = S_DT_RISE;
              cnt_d   = dt_rise;
            end else begin
              state_d = S_HIGH;
            end
          end else begin
            if (dt_eff_f) begin
              state_d = S_DT_FALL;
              cnt_d   = dt_fall;
            end else begin
              state_d = S_LOW;
            end
          end
        end
        S_LOW: begin
          if (pwm_in) begin
            if (dt_eff_r) begin
              state_d = S_DT_RISE;
              cnt_d   = dt_rise;
            end else begin
              state_d = S_HIGH;
            end
          end
        end
        S_DT_RISE: begin
          if (!pwm_in) begin
            state_d = S_LOW;
          end else if (cnt_q == DT_WIDTH'(1)) begin
            state_d = S_HIGH;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        S_HIGH: begin
          if (!pwm_in) begin
            if (dt_eff_f) begin
              state_d = S_DT_FALL;
              cnt_d   = dt_fall;
            end else begin
              state_d = S_LOW;
            end
          end
        end
        S_DT_FALL: begin
          if (pwm_in) begin
            state_d = S_HIGH;
          end else if (cnt_q == DT_WIDTH'(1)) begin
            state_d = S_LOW;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        default: begin
          state_d = S_OFF;
        end
      endcase
    end
    pwm_h_d   = (state_d == S_HIGH) ^ pol;
    pwm_l_d   = (state_d == S_LOW) ^ pol;
    dt_busy_d = (state_d == S_DT_RISE) || (state_d == S_DT_FALL);
  end

  // State, counter and output flops; reset forces both gates to the inactive level.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      pwm_h_q   <= pol;
      pwm_l_q   <= pol;
      dt_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pwm_h_q   <= pwm_h_d;
      pwm_l_q   <= pwm_l_d;
      dt_busy_q <= dt_busy_d;
    end
  end

  assign pwm_h   = pwm_h_q;
  assign pwm_l   = pwm_l_q;
  assign dt_busy = dt_busy_q;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Self-checking bench for pwm_deadtime_gen.
// Expected {pwm_h, pwm_l, dt_busy} queued per driven cycle, popped one clk later.
// Inputs change between edges; outputs sampled 1ns after each rising edge.
module tb_pwm_deadtime_gen;
  import pwm_deadtime_gen_pkg::*;

  logic      clk;
  logic      rstn;
  logic      ce;
  _pwm_onoff pwm_on;
  _dt_onoff  dt_on;
  _logic_pwm logic_pol;
  logic [7:0] dt_rise;
  logic [7:0] dt_fall;
  logic      pwm_in;
  logic      pwm_h;
  logic      pwm_l;
  logic      dt_busy;

  logic [2:0] exp_q[$];
  logic [2:0] e;
  int passed;
  int checks;

  pwm_deadtime_gen #(.DT_WIDTH(8)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ce       (ce),
    .pwm_on   (pwm_on),
    .dt_on    (dt_on),
    .logic_pol(logic_pol),
    .dt_rise  (dt_rise),
    .dt_fall  (dt_fall),
    .pwm_in   (pwm_in),
    .pwm_h    (pwm_h),
    .pwm_l    (pwm_l),
    .dt_busy  (dt_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue its expected outputs, advance past the edge.
  task automatic apply(input logic ce_v, input logic pin_v, input logic [2:0] exp_v);
    ce     = ce_v;
    pwm_in = pin_v;
    exp_q.push_back(exp_v);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; pwm_on = PWM_ON; dt_on = DT_ON; dt_rise = 8'd3; dt_fall = 8'd3;
    logic_pol = LOGIC_NEG;
    apply(1'b1, 1'b0, 3'b110);
    e = exp_q.pop_front(); checks++;
    if ({pwm_h, pwm_l, dt_busy} !== e)
      $display("FAIL reset_neg: h/l/busy got %b%b%b want %b", pwm_h, pwm_l, dt_busy, e);
    else passed++;
    logic_pol = LOGIC_POS;
    apply(1'b1, 1'b0, 3'b000);
    e = exp_q.pop_front(); checks++;
    if ({pwm_h, pwm_l, dt_busy} !== e)
      $display("FAIL reset_pos: h/l/busy got %b%b%b want %b", pwm_h, pwm_l, dt_busy, e);
    else passed++;
    // Leaving reset with pwm_in low must still run a full falling dead time.
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, (i < 3) ? 3'b001 : 3'b010);
      e = exp_q.pop_front(); checks++;
      if ({pwm_h, pwm_l, dt_busy} !== e)
        $display("FAIL reset_exit step %0d: h/l/busy got %b%b%b want %b", i, pwm_h, pwm_l, dt_busy, e);
      else passed++;
    end
  endtask

  task automatic test_basic_rise_fall();
    logic [2:0] want;
    for (int i = 0; i < 9; i++) begin
      if (i < 3)      want = 3'b001;
      else if (i < 5) want = 3'b100;
      else if (i < 8) want = 3'b001;
      else            want = 3'b010;
      apply(1'b1, (i < 5), want);
      e = exp_q.pop_front(); checks++;
      if ({pwm_h, pwm_l, dt_busy} !== e)
        $display("FAIL basic step %0d: h/l/busy got %b%b%b want %b", i, pwm_h, pwm_l, dt_busy, e);
      else passed++;
    end
  endtask

  task automatic test_glitch();
    dt_rise = 8'd5;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, (i < 2), (i < 2) ? 3'b001 : 3'b010);
      e = exp_q.pop_front(); checks++;
      if ({pwm_h, pwm_l, dt_busy} !== e)
        $display("FAIL glitch step %0d: h/l/busy got %b%b%b want %b", i, pwm_h, pwm_l, dt_busy, e);
      else passed++;
    end
    dt_rise = 8'd3;
  endtask

  task automatic test_no_deadtime();
    for (int i = 0; i < 4; i++) begin
      dt_on   = (i < 2) ? DT_OFF : DT_ON;
      dt_rise = (i < 2) ? 8'd3 : 8'd0;
      dt_fall = (i == 3) ? 8'd0 : 8'd3;
      apply(1'b1, (i % 2 == 0), (i % 2 == 0) ? 3'b100 : 3'b010);
      e = exp_q.pop_front(); checks++;
      if ({pwm_h, pwm_l, dt_busy} !== e)
        $display("FAIL no_dt step %0d: h/l/busy got %b%b%b want %b", i, pwm_h, pwm_l, dt_busy, e);
      else passed++;
    end
    dt_on = DT_ON; dt_rise = 8'd3; dt_fall = 8'd3;
  endtask

  task automatic test_ce_gating();
    logic [2:0] want;
    dt_rise = 8'd2;
    // ce pulses at i = 2, 6, 10; the rise is first sampled at i = 2.
    for (int i = 0; i < 14; i++) begin
      if (i < 2)       want = 3'b010;
      else if (i < 10) want = 3'b001;
      else             want = 3'b100;
      apply((i % 4 == 2), 1'b1, want);
      e = exp_q.pop_front(); checks++;
      if ({pwm_h, pwm_l, dt_busy} !== e)
        $display("FAIL ce_gate step %0d: h/l/busy got %b%b%b want %b", i, pwm_h, pwm_l, dt_busy, e);
      else passed++;
    end
    dt_rise = 8'd3;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, (i < 3) ? 3'b001 : 3'b010);
      e = exp_q.pop_front(); checks++;
      if ({pwm_h, pwm_l, dt_busy} !== e)
        $display("FAIL ce_return step %0d: h/l/busy got %b%b%b want %b", i, pwm_h, pwm_l, dt_busy, e);
      else passed++;
    end
  endtask

  task automatic test_polarity_disable_reset();
    logic [2:0] want;
    logic       ce_v, pin_v;
    for (int i = 0; i < 18; i++) begin
      ce_v = 1'b1; pin_v = 1'b1;
      case (i)
        0, 1, 2: want = 3'b001;
        3:       want = 3'b100;
        4: begin logic_pol = LOGIC_NEG; want = 3'b010; end
        5, 6: begin pwm_on = PWM_OFF; ce_v = 1'b0; want = 3'b110; end
        7: begin pwm_on = PWM_ON; logic_pol = LOGIC_POS; want = 3'b001; end
        8, 9:    want = 3'b001;
        10:      want = 3'b100;
        11: begin pin_v = 1'b0; want = 3'b001; end
        12: begin rstn = 1'b0; pin_v = 1'b0; want = 3'b000; end
        13, 14, 15: begin rstn = 1'b1; pin_v = 1'b0; want = 3'b001; end
        default: begin pin_v = 1'b0; want = 3'b010; end
      endcase
      apply(ce_v, pin_v, want);
      e = exp_q.pop_front(); checks++;
      if ({pwm_h, pwm_l, dt_busy} !== e)
        $display("FAIL pol_dis_rst step %0d: h/l/busy got %b%b%b want %b", i, pwm_h, pwm_l, dt_busy, e);
      else passed++;
    end
  endtask

  task automatic test_reprogram();
    logic [2:0] want;
    logic       pin_v;
    dt_rise = 8'd4;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) dt_rise = 8'd1;
      pin_v = (i < 5) || (i >= 9);
      if (i < 4)       want = 3'b001;
      else if (i == 4) want = 3'b100;
      else if (i < 8)  want = 3'b001;
      else if (i == 8) want = 3'b010;
      else if (i == 9) want = 3'b001;
      else             want = 3'b100;
      apply(1'b1, pin_v, want);
      e = exp_q.pop_front(); checks++;
      if ({pwm_h, pwm_l, dt_busy} !== e)
        $display("FAIL reprogram step %0d: h/l/busy got %b%b%b want %b", i, pwm_h, pwm_l, dt_busy, e);
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    checks = 0;
    rstn = 1'b0; ce = 1'b1; pwm_in = 1'b0;
    pwm_on = PWM_ON; dt_on = DT_ON; logic_pol = LOGIC_POS;
    dt_rise = 8'd3; dt_fall = 8'd3;
    test_reset();
    test_basic_rise_fall();
    test_glitch();
    test_no_deadtime();
    test_ce_gating();
    test_polarity_disable_reset();
    test_reprogram();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
